cdb_arbiter: RTL and testbench



---
 rtl/cdb_pkg.sv | 21 ++
 rtl/rr_priority_picker.sv | 33 +++
 rtl/cdb_arbiter.sv | 87 ++++++++
 tb/tb_cdb_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default widths, tag type and the broadcast bundle seen by
// producers and listeners.
package cdb_pkg;

  localparam int unsigned CdbDataWidth = 4;
  localparam int unsigned CdbTagWidth  = 4;

  typedef logic [CdbTagWidth-1:0] cdb_tag_t;

  typedef struct packed {
    logic                    valid;
    cdb_tag_t                tag;
    logic [CdbDataWidth-1:0] data;
  } cdb_bcast_t;

  // A single requester still needs a 1-bit pointer.
  function automatic int unsigned ptr_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping,
// returned both one-hot and as a binary index.
module rr_priority_picker
  import cdb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned PtrW   = ptr_width(NumReq)
) (
  input  logic [NumReq-1:0] i_req,
  input  logic [PtrW-1:0]   i_ptr,
  output logic [NumReq-1:0] o_grant,
  output logic [PtrW-1:0]   o_idx,
  output logic              o_found
);

  int unsigned w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < NumReq; k++) begin
      w_j = (32'(i_ptr) + 32'(k)) % NumReq;
      if (!o_found && i_req[w_j]) begin
        o_found       = 1'b1;
        o_grant[w_j]  = 1'b1;
        o_idx         = PtrW'(w_j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with a registered single broadcast. Defining
// CDB_ARBITER_PERF_COUNT_EN adds the saturating cdb_busy_count grant counter.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_WIDTH    = CdbDataWidth,
  parameter int unsigned CDB_TAG_WIDTH = CdbTagWidth
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          cdb_hold,
  output logic [NUM_REQ-1:0]            accepted,
`ifdef CDB_ARBITER_PERF_COUNT_EN
  output logic [15:0]                   cdb_busy_count,
`endif
  output logic                          cdb_valid,
  output logic [CDB_TAG_WIDTH-1:0]      cdb_tag,
  output logic [DATA_WIDTH-1:0]         cdb_data
);

  localparam int unsigned PtrW = ptr_width(NUM_REQ);

  logic [PtrW-1:0]       r_ptr;
  logic [NUM_REQ-1:0]    w_grant;
  logic [PtrW-1:0]       w_idx;
  logic                  w_found;
  logic                  w_fire;
  logic [PtrW-1:0]       w_ptr_nxt;
  logic [DATA_WIDTH-1:0] w_sel_data;

  rr_priority_picker #(
    .NumReq (NUM_REQ),
    .PtrW   (PtrW)
  ) u_picker (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  // rst gates the grant too, so producers never see an accept they can't complete.
  assign w_fire    = w_found & ~cdb_hold & ~rst;
  assign accepted  = w_fire ? w_grant : '0;
  assign w_ptr_nxt = (w_idx == PtrW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else begin
      cdb_valid <= w_fire;
      if (w_fire) begin
        r_ptr    <= w_ptr_nxt;
        cdb_tag  <= CDB_TAG_WIDTH'(w_idx);
        cdb_data <= w_sel_data;
      end
    end
  end

`ifdef CDB_ARBITER_PERF_COUNT_EN
  logic [15:0] r_busy_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy_count <= '0;
    end else if (w_fire && (r_busy_count != 16'hFFFF)) begin
      r_busy_count <= r_busy_count + 16'd1;
    end
  end

  assign cdb_busy_count = r_busy_count;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default 4 requesters, 4-bit data/tag).
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic        cdb_hold;
  logic [3:0]  accepted;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [3:0]  cdb_data;
`ifdef CDB_ARBITER_PERF_COUNT_EN
  logic [15:0] cdb_busy_count;
`endif

  int checks;
  int failures;

  // Slice data: 0 -> 5, 1 -> C, 2 -> 9, 3 -> 3.
  logic [3:0] exp_d [4] = '{4'h5, 4'hC, 4'h9, 4'h3};

  cdb_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_data       (req_data),
    .cdb_hold       (cdb_hold),
    .accepted       (accepted),
`ifdef CDB_ARBITER_PERF_COUNT_EN
    .cdb_busy_count (cdb_busy_count),
`endif
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = 4'b0000;
    cdb_hold = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    req_data = 16'h39C5;
    cdb_hold = 1'b0;
    req      = 4'b1111;
    rst      = 1'b1;
    #2;
    checks++;
    if (accepted !== 4'b0000) begin
      failures++; $display("FAIL reset_acc got=%b exp=%b", accepted, 4'b0000);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data} !== 9'h000) begin
      failures++;
      $display("FAIL reset_out got=%b/%h/%h exp=0/0/0", cdb_valid, cdb_tag, cdb_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (accepted !== 4'b0001) begin
      failures++; $display("FAIL reset_first_acc got=%b exp=%b", accepted, 4'b0001);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'h0, 4'h5}) begin
      failures++;
      $display("FAIL reset_first_bc got=%b/%h/%h exp=1/0/5", cdb_valid, cdb_tag, cdb_data);
    end
    // Mid-cycle assertion must clear the broadcast without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data, accepted} !== 13'h0) begin
      failures++;
      $display("FAIL reset_async got=%b/%h/%h/%b exp=0/0/0/0000",
               cdb_valid, cdb_tag, cdb_data, accepted);
    end
    tick();
    rst = 1'b0;
    req = 4'b0000;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    #1;
    checks++;
    if (accepted !== 4'b0100) begin
      failures++; $display("FAIL single_acc got=%b exp=%b", accepted, 4'b0100);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'h2, 4'h9}) begin
      failures++;
      $display("FAIL single_bc got=%b/%h/%h exp=1/2/9", cdb_valid, cdb_tag, cdb_data);
    end
    req = 4'b1111;
    #1;
    checks++;
    if (accepted !== 4'b1000) begin
      failures++; $display("FAIL single_ptr3 got=%b exp=%b", accepted, 4'b1000);
    end
    tick();
    req = 4'b0000;
    #1;
    checks++;
    if (accepted !== 4'b0000) begin
      failures++; $display("FAIL idle_acc got=%b exp=%b", accepted, 4'b0000);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data} !== {1'b0, 4'h3, 4'h3}) begin
      failures++;
      $display("FAIL idle_hold got=%b/%h/%h exp=0/3/3", cdb_valid, cdb_tag, cdb_data);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_acc;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_acc = 4'b0001 << (k % 4);
      checks++;
      if (accepted !== exp_acc) begin
        failures++; $display("FAIL fair_acc[%0d] got=%b exp=%b", k, accepted, exp_acc);
      end
      tick();
      checks++;
      if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'(k % 4), exp_d[k % 4]}) begin
        failures++;
        $display("FAIL fair_bc[%0d] got=%b/%h/%h exp=1/%h/%h", k, cdb_valid, cdb_tag,
                 cdb_data, k % 4, exp_d[k % 4]);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_rotation_skip();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0011;
    #1;
    checks++;
    if (accepted !== 4'b0001) begin
      failures++; $display("FAIL skip_acc0 got=%b exp=%b", accepted, 4'b0001);
    end
    tick();
    checks++;
    if (accepted !== 4'b0010) begin
      failures++; $display("FAIL skip_acc1 got=%b exp=%b", accepted, 4'b0010);
    end
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'h0, 4'h5}) begin
      failures++;
      $display("FAIL skip_bc0 got=%b/%h/%h exp=1/0/5", cdb_valid, cdb_tag, cdb_data);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'h1, 4'hC}) begin
      failures++;
      $display("FAIL skip_bc1 got=%b/%h/%h exp=1/1/c", cdb_valid, cdb_tag, cdb_data);
    end
    req = 4'b0000;
  endtask

  task automatic test_hold();
    do_reset();
    req      = 4'b0010;
    cdb_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (accepted !== 4'b0000) begin
        failures++; $display("FAIL hold_acc[%0d] got=%b exp=%b", k, accepted, 4'b0000);
      end
      tick();
      checks++;
      if (cdb_valid !== 1'b0) begin
        failures++; $display("FAIL hold_valid[%0d] got=%b exp=0", k, cdb_valid);
      end
    end
    cdb_hold = 1'b0;
    #1;
    checks++;
    if (accepted !== 4'b0010) begin
      failures++; $display("FAIL hold_rel_acc got=%b exp=%b", accepted, 4'b0010);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'h1, 4'hC}) begin
      failures++;
      $display("FAIL hold_rel_bc got=%b/%h/%h exp=1/1/c", cdb_valid, cdb_tag, cdb_data);
    end
    // ptr was frozen at 0 by the hold, so after granting 1 it sits at 2.
    req = 4'b1011;
    #1;
    checks++;
    if (accepted !== 4'b1000) begin
      failures++; $display("FAIL hold_ptr got=%b exp=%b", accepted, 4'b1000);
    end
    tick();
    req = 4'b0000;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0001;
    tick();
    req_data = 16'h39CA;
    #1;
    checks++;
    if (accepted !== 4'b0001) begin
      failures++; $display("FAIL b2b_acc got=%b exp=%b", accepted, 4'b0001);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'h0, 4'hA}) begin
      failures++;
      $display("FAIL b2b_bc got=%b/%h/%h exp=1/0/a", cdb_valid, cdb_tag, cdb_data);
    end
    req      = 4'b0000;
    req_data = 16'h39C5;
  endtask

`ifdef CDB_ARBITER_PERF_COUNT_EN
  task automatic test_perf_count();
    do_reset();
    checks++;
    if (cdb_busy_count !== 16'd0) begin
      failures++; $display("FAIL perf_reset got=%0d exp=0", cdb_busy_count);
    end
    req = 4'b1111;
    repeat (3) tick();
    req = 4'b0000;
    repeat (2) tick();
    req = 4'b0101;
    repeat (2) tick();
    req = 4'b0000;
    tick();
    checks++;
    if (cdb_busy_count !== 16'd5) begin
      failures++; $display("FAIL perf_count got=%0d exp=5", cdb_busy_count);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = 4'b0000;
    req_data = 16'h39C5;
    cdb_hold = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_rotation_skip();
    test_hold();
    test_back_to_back();
`ifdef CDB_ARBITER_PERF_COUNT_EN
    test_perf_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
